fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/if_id_reg.sv | 61 ++++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction size, reset PC, the NOP
// word, and the IF/ID pipeline-register layout.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'hE1A0_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] pc_plus8;
        logic            valid;
    } if_id_t;

    // Offsets wrap modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] pc, input int bytes);
        return pc + XLEN'(bytes);
    endfunction

    // Instructions are word aligned, so the low two address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register for one instruction and its PC values. Flush takes priority
// over stall, which takes priority over a normal load.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [XLEN-1:0] pc_plus8_out,
    output logic            valid_out
);

    if_id_t stage_q;
    if_id_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            // A flushed slot still carries the PC values of the squashed fetch.
            stage_d.instr    = NOP_WORD;
            stage_d.pc       = pc_in;
            stage_d.pc_plus4 = pc_add(pc_in, INSTR_BYTES);
            stage_d.pc_plus8 = pc_add(pc_in, 2 * INSTR_BYTES);
            stage_d.valid    = 1'b0;
        end else if (!stall) begin
            stage_d.instr    = instr_in;
            stage_d.pc       = pc_in;
            stage_d.pc_plus4 = pc_add(pc_in, INSTR_BYTES);
            stage_d.pc_plus8 = pc_add(pc_in, 2 * INSTR_BYTES);
            stage_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q.instr    <= NOP_WORD;
            stage_q.pc       <= RESET_PC;
            stage_q.pc_plus4 <= pc_add(RESET_PC, INSTR_BYTES);
            stage_q.pc_plus8 <= pc_add(RESET_PC, 2 * INSTR_BYTES);
            stage_q.valid    <= 1'b0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign instr_out    = stage_q.instr;
    assign pc_out       = stage_q.pc;
    assign pc_plus4_out = stage_q.pc_plus4;
    assign pc_plus8_out = stage_q.pc_plus8;
    assign valid_out    = stage_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the asynchronous ROM and fills IF/ID.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic [31:0] pc_plus8_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        valid_d
);

    logic [31:0] pc_f_q;
    logic [31:0] pc_f_d;
    logic        if_id_flush;

    // A redirect squashes the wrong-path fetch even while the stage is stalled.
    assign if_id_flush = flush_d | branch_taken_e;

    always_comb begin
        pc_f_d = pc_f_q;
        if (branch_taken_e) begin
            pc_f_d = word_align(branch_target_e);
        end else if (!stall_f) begin
            pc_f_d = pc_add(pc_f_q, INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    assign imem_addr = pc_f_q;

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall_f),
        .flush        (if_id_flush),
        .instr_in     (imem_rdata),
        .pc_in        (pc_f_q),
        .instr_out    (instr_d),
        .pc_out       (pc_d),
        .pc_plus4_out (pc_plus4_d),
        .pc_plus8_out (pc_plus8_d),
        .valid_out    (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!if_id_flush && !stall_f) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_f && !branch_taken_e) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control traffic checked against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic        branch_taken_e = 1'b0;
    logic [31:0] branch_target_e = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] pc_plus8_d;
    logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // 256-word ROM, indexed by address bits only.
    logic [31:0] rom_mem [0:255];
    assign imem_rdata = rom_mem[imem_addr[9:2]];

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_f         (stall_f),
        .flush_d         (flush_d),
        .branch_taken_e  (branch_taken_e),
        .branch_target_e (branch_target_e),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .pc_plus4_d      (pc_plus4_d),
        .pc_plus8_d      (pc_plus8_d),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt),
`endif
        .valid_d         (valid_d)
    );

    // Drive one cycle of controls, advance the model across the edge, settle.
    task automatic step(input logic rst_n, input logic st, input logic fl,
                        input logic br, input logic [31:0] tgt);
        logic [31:0] word_now;
        @(negedge clk);
        reset_n = rst_n;
        stall_f = st;
        flush_d = fl;
        branch_taken_e = br;
        branch_target_e = tgt;
        word_now = rom_mem[m_pc[9:2]];
        @(posedge clk);
        if (!rst_n) begin
            m_pc = RESET_PC; m_instr = NOP; m_pcd = RESET_PC; m_valid = 1'b0;
            m_fcnt = '0; m_scnt = '0;
        end else begin
            if (fl || br) begin
                m_instr = NOP; m_valid = 1'b0; m_pcd = m_pc;
            end else if (!st) begin
                m_instr = word_now; m_valid = 1'b1; m_pcd = m_pc;
                m_fcnt = m_fcnt + 1;
            end
            if (st && !br) m_scnt = m_scnt + 1;
            if (br) m_pc = {tgt[31:2], 2'b00};
            else if (!st) m_pc = m_pc + 4;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, RESET_PC); end
        checks++; if (instr_d !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_d, NOP); end
        checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
        checks++; if ({pc_d, pc_plus4_d, pc_plus8_d} !== {RESET_PC, RESET_PC + 32'd4, RESET_PC + 32'd8}) begin
            failures++; $display("FAIL reset_pcs got=%h/%h/%h", pc_d, pc_plus4_d, pc_plus8_d);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_words [3];
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, '0);
            checks++; if (instr_d !== exp_words[i] || valid_d !== 1'b1) begin
                failures++; $display("FAIL seq_instr[%0d] got=%h v=%b exp=%h v=1", i, instr_d, valid_d, exp_words[i]);
            end
            checks++; if (imem_addr !== 32'(4 * (i + 1))) begin
                failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0);
            checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stall_pc got=%h exp=8", imem_addr); end
            checks++; if (instr_d !== 32'h22 || pc_d !== 32'h4 || valid_d !== 1'b1) begin
                failures++; $display("FAIL stall_hold got=%h/%h/%b exp=22/4/1", instr_d, pc_d, valid_d);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (instr_d !== 32'h33 || pc_d !== 32'h8 || imem_addr !== 32'hC) begin
            failures++; $display("FAIL stall_resume got=%h/%h/%h exp=33/8/c", instr_d, pc_d, imem_addr);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_branch();
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL branch_start got=%h exp=10", imem_addr); end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0043);
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL branch_pc got=%h exp=40", imem_addr); end
        checks++; if (instr_d !== NOP || valid_d !== 1'b0) begin
            failures++; $display("FAIL branch_bubble got=%h/%b exp=%h/0", instr_d, valid_d, NOP);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (instr_d !== rom_mem[16] || pc_d !== 32'h40 || pc_plus8_d !== 32'h48 || valid_d !== 1'b1) begin
            failures++; $display("FAIL branch_target got=%h/%h/%h/%b exp=%h/40/48/1", instr_d, pc_d, pc_plus8_d, valid_d, rom_mem[16]);
        end
    endtask

    task automatic test_branch_stall();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020);
        checks++; if (imem_addr !== 32'h20 || valid_d !== 1'b0 || instr_d !== NOP) begin
            failures++; $display("FAIL branch_stall got=%h/%b/%h exp=20/0/%h", imem_addr, valid_d, instr_d, NOP);
        end
    endtask

    task automatic test_flush_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        checks++; if (imem_addr !== 32'h24 || valid_d !== 1'b0 || instr_d !== NOP) begin
            failures++; $display("FAIL flush_stall got=%h/%b/%h exp=24/0/%h", imem_addr, valid_d, instr_d, NOP);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load got=%h exp=fffffffc", imem_addr); end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", imem_addr); end
        checks++; if (pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0 || pc_plus8_d !== 32'h4 || instr_d !== rom_mem[255]) begin
            failures++; $display("FAIL wrap_ifid got=%h/%h/%h/%h", pc_d, pc_plus4_d, pc_plus8_d, instr_d);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        checks++; if (imem_addr !== RESET_PC || valid_d !== 1'b0 || instr_d !== NOP) begin
            failures++; $display("FAIL mid_reset got=%h/%b/%h", imem_addr, valid_d, instr_d);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (pc_d !== RESET_PC || instr_d !== 32'h11) begin
            failures++; $display("FAIL post_reset got=%h/%h exp=%h/11", pc_d, instr_d, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic rst_n, st, fl, br;
        logic [31:0] tgt;
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            st    = ($urandom_range(0, 3) == 0);
            fl    = ($urandom_range(0, 7) == 0);
            br    = ($urandom_range(0, 7) == 0);
            tgt   = (i % 50 == 7) ? 32'hFFFF_FFF9 : {22'(0), 10'($urandom)};
            step(rst_n, st, fl, br, tgt);
            checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, imem_addr, m_pc); end
            checks++; if (instr_d !== m_instr || valid_d !== m_valid) begin
                failures++; $display("FAIL rnd_instr[%0d] got=%h/%b exp=%h/%b", i, instr_d, valid_d, m_instr, m_valid);
            end
            checks++; if (pc_d !== m_pcd || pc_plus4_d !== m_pcd + 32'd4 || pc_plus8_d !== m_pcd + 32'd8) begin
                failures++; $display("FAIL rnd_pcs[%0d] got=%h/%h/%h exp=%h", i, pc_d, pc_plus4_d, pc_plus8_d, m_pcd);
            end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        checks++; if (fetch_cnt !== m_fcnt) begin failures++; $display("FAIL fetch_cnt got=%0d exp=%0d", fetch_cnt, m_fcnt); end
        checks++; if (stall_cnt !== m_scnt) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, m_scnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rom_mem[0] = 32'h11; rom_mem[1] = 32'h22; rom_mem[2] = 32'h33;
        m_pc = RESET_PC; m_instr = NOP; m_pcd = RESET_PC; m_valid = 1'b0;
        m_fcnt = '0; m_scnt = '0;

        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_flush_stall();
        test_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_mid_reset();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
